// File: rtl/i2s_dac_tx_if.sv
// i2s_dac_tx_if: sample-side handshake between the voice/NCO output and the I2S transmitter
interface i2s_dac_tx_if;
  logic        enable;
  logic        mute;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        sample_tick;
  modport master (output enable, mute, left_in, right_in, input sample_tick);
  modport slave (input enable, mute, left_in, right_in, output sample_tick);
endinterface

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: self-clocked I2S transmitter, captures one stereo sample per frame and shifts it out MSB first
module i2s_dac_tx #(
  parameter int HALF_DIV  = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  i2s_dac_tx_if.slave  bus,
  output logic         AUD_BCLK,
  output logic         AUD_DACLRCK,
  output logic         AUD_DACDAT
);
  localparam int DW = $clog2(HALF_DIV + 1);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [DW-1:0] DIV_MAX = DW'(HALF_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT    = BW'(SLOT_BITS);
  localparam logic [BW-1:0] P_LAST  = BW'(16);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state, state_n;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, nb, p;
  logic [31:0]   sh;
  logic          tick, wrap, fall, start, stop, data_bit;
  assign bus.sample_tick = tick;
  // frame sequencing: a fall event on the last bit either restarts the frame or stops
  always_comb begin
    wrap     = div_cnt == DIV_MAX;
    fall     = state == RUN && wrap && AUD_BCLK;
    stop     = fall && bit_cnt == BIT_MAX && !bus.enable;
    start    = state == IDLE ? bus.enable : fall && bit_cnt == BIT_MAX && bus.enable;
    state_n  = start ? RUN : stop ? IDLE : state;
    nb       = bit_cnt + BW'(1);
    p        = nb >= SLOT ? nb - SLOT : nb;
    data_bit = p != '0 && p <= P_LAST;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // counters, bit clock and serializer; {left,right} shifts only in data positions so right follows left
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      tick        <= 1'b0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
    end else if (start || state_n == IDLE) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      sh          <= start && !bus.mute ? {bus.left_in, bus.right_in} : '0;
      tick        <= start;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
      AUD_DACDAT  <= 1'b0;
    end else begin
      tick     <= 1'b0;
      div_cnt  <= wrap ? '0 : div_cnt + DW'(1);
      AUD_BCLK <= AUD_BCLK ^ wrap;
      if (fall) begin
        bit_cnt     <= nb;
        AUD_DACLRCK <= nb >= SLOT;
        AUD_DACDAT  <= data_bit & sh[31];
        if (data_bit) sh <= {sh[30:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: directed scoreboard bench for i2s_dac_tx across three parameter sets
module tb_i2s_dac_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en = '0;
  logic        mute = 1'b0;
  logic [15:0] left = '0, right = '0;
  logic [2:0]  bclk, lrck, dat, tick;
  int          sel = 0, errors = 0, checks = 0;
  logic        bclk_prev = 1'b0;
  logic [1:0]  e;
  logic [1:0]  exp_q[$];
  i2s_dac_tx_if b0 (), b1 (), b2 ();
  assign b0.enable = en[0];
  assign b1.enable = en[1];
  assign b2.enable = en[2];
  assign b0.mute = mute;
  assign b1.mute = mute;
  assign b2.mute = mute;
  assign b0.left_in = left;
  assign b1.left_in = left;
  assign b2.left_in = left;
  assign b0.right_in = right;
  assign b1.right_in = right;
  assign b2.right_in = right;
  assign tick = {b2.sample_tick, b1.sample_tick, b0.sample_tick};
  i2s_dac_tx dut0 (.clk(clk), .rst_n(rst_n), .bus(b0), .AUD_BCLK(bclk[0]), .AUD_DACLRCK(lrck[0]), .AUD_DACDAT(dat[0]));
  i2s_dac_tx #(.HALF_DIV(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .AUD_BCLK(bclk[1]), .AUD_DACLRCK(lrck[1]), .AUD_DACDAT(dat[1]));
  i2s_dac_tx #(.HALF_DIV(1), .SLOT_BITS(17)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .AUD_BCLK(bclk[2]), .AUD_DACLRCK(lrck[2]), .AUD_DACDAT(dat[2]));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic void push_frame(input logic [15:0] l, input logic [15:0] r, input int sb);
    for (int k = 0; k < 2 * sb; k++) begin
      int p = k % sb;
      logic [15:0] s = k >= sb ? r : l;
      logic b = 1'b0;
      if (p >= 1 && p <= 16) b = s[16-p];
      exp_q.push_back({k >= sb, b});
    end
  endfunction
  // codec view: every BCLK rising edge consumes one expected {LRCK, DACDAT} pair
  always @(negedge clk) begin
    if (bclk[sel] && !bclk_prev) begin
      if (exp_q.size() == 0) chk("sb_extra_bclk", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        chk("sb_lrck_dat", {30'b0, lrck[sel], dat[sel]}, {30'b0, e});
      end
    end
    bclk_prev = bclk[sel];
  end
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input logic m, input int half, input int sb, input int drop_at);
    int period = 4 * half * sb;
    left = l;
    right = r;
    mute = m;
    push_frame(m ? 16'h0 : l, m ? 16'h0 : r, sb);
    for (int j = 0; j < period; j++) begin
      @(negedge clk);
      if (j == 0) chk("tick", 32'(tick[sel]), 32'd1);
      else chk("no_tick", 32'(tick[sel]), 32'd0);
      if (j == 0) chk("lrck_start", 32'(lrck[sel]), 32'd0);
      if (j == half - 1) chk("bclk_low", 32'(bclk[sel]), 32'd0);
      if (j == half) chk("bclk_rise", 32'(bclk[sel]), 32'd1);
      if (j == period / 2 - 1) chk("lrck_left", 32'(lrck[sel]), 32'd0);
      if (j == period / 2) chk("lrck_right", 32'(lrck[sel]), 32'd1);
      if (j == drop_at) en[sel] = 1'b0;
      left = 16'($urandom);
      right = 16'($urandom);
      mute = 1'($urandom);
    end
  endtask
  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_out", {28'b0, tick[sel], bclk[sel], lrck[sel], dat[sel]}, 32'd0);
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("reset_out", {28'b0, tick[i], bclk[i], lrck[i], dat[i]}, 32'd0);
    rst_n = 1'b1;
    sel = 1;
    en[1] = 1'b1;
    left = 16'h0F0F;
    right = 16'hFFFF;
    push_frame(left, right, 32);
    for (int j = 0; j <= 134; j++) begin
      @(negedge clk);
      if (j == 0) chk("reset_tick", 32'(tick[1]), 32'd1);
    end
    chk("pre_reset", {29'b0, bclk[1], lrck[1], dat[1]}, 32'd7);
    #2 rst_n = 1'b0;
    en[1] = 1'b0;
    #1 chk("async_reset", {28'b0, tick[1], bclk[1], lrck[1], dat[1]}, 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    idle_check(20);
    sel = 0;
    en[0] = 1'b1;
    frame(16'h8001, 16'h7FFE, 1'b0, 16, 32, -1);
    repeat (3) frame(16'($urandom), 16'($urandom), 1'b0, 16, 32, -1);
    frame(16'h1234, 16'h5678, 1'b1, 16, 32, -1);
    frame(16'h1234, 16'h5678, 1'b0, 16, 32, 330);
    idle_check(10);
    sel = 2;
    en[2] = 1'b1;
    frame(16'hA5C3, 16'h3C5A, 1'b0, 1, 17, -1);
    frame(16'hFFFF, 16'h8001, 1'b0, 1, 17, 21);
    idle_check(10);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
